// File: rtl/kyber_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// kyber_phase_defs : shared phase codes, mode encodings and phase ordering
// Rev 1.0 - initial release
// ============================================================================
package kyber_phase_defs;

    localparam logic [3:0] c_PH_IDLE    = 4'd0;
    localparam logic [3:0] c_PH_UNPACK  = 4'd1;
    localparam logic [3:0] c_PH_NTT     = 4'd2;
    localparam logic [3:0] c_PH_PACC    = 4'd3;
    localparam logic [3:0] c_PH_INTT    = 4'd4;
    localparam logic [3:0] c_PH_SUB     = 4'd5;
    localparam logic [3:0] c_PH_REDUCE  = 4'd6;
    localparam logic [3:0] c_PH_TOMSG   = 4'd7;
    localparam logic [3:0] c_PH_FROMMSG = 4'd8;
    localparam logic [3:0] c_PH_HASH    = 4'd9;
    localparam logic [3:0] c_PH_ADD     = 4'd10;
    localparam logic [3:0] c_PH_PACK    = 4'd11;
    localparam logic [3:0] c_PH_ERR     = 4'd15;

    localparam logic c_MODE_ENC = 1'b0;
    localparam logic c_MODE_DEC = 1'b1;

    localparam int KYBER_K = 2;

    // last_pass: the PAcc/INTT loop is on its final (V) polynomial
    function automatic logic [3:0] next_phase(input logic [3:0] cur,
                                              input logic       mode,
                                              input logic       last_pass);
        logic [3:0] nxt;
        nxt = c_PH_IDLE;
        case (cur)
            c_PH_UNPACK:  nxt = c_PH_NTT;
            c_PH_NTT:     nxt = (mode == c_MODE_DEC) ? c_PH_PACC : c_PH_HASH;
            c_PH_HASH:    nxt = c_PH_PACC;
            c_PH_PACC:    nxt = c_PH_INTT;
            c_PH_INTT:    nxt = (mode == c_MODE_DEC) ? c_PH_SUB :
                                (last_pass ? c_PH_FROMMSG : c_PH_PACC);
            c_PH_SUB:     nxt = c_PH_REDUCE;
            c_PH_REDUCE:  nxt = (mode == c_MODE_DEC) ? c_PH_TOMSG : c_PH_PACK;
            c_PH_FROMMSG: nxt = c_PH_ADD;
            c_PH_ADD:     nxt = c_PH_REDUCE;
            default:      nxt = c_PH_IDLE;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kyber_phase_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// phase_watchdog : per-phase cycle counter with timeout flag
// Rev 1.0 - initial release
// ============================================================================
module phase_watchdog #(
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic busy_i,
    output logic timeout_o
);

    localparam logic [TO_W-1:0] c_LAST = TIMEOUT - TO_W'(1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !busy_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = busy_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/kyber_phase_sequencer.sv
`default_nettype none
// ============================================================================
// kyber_phase_sequencer : Kyber512 IND-CPA ENC/DEC phase sequencer
// Rev 1.0 - initial release
// ============================================================================
module kyber_phase_sequencer
    import kyber_phase_defs::*;
#(
    parameter int              K       = 2,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_start,
    input  logic       op_mode,
    input  logic       op_abort,
    input  logic       err_clr,
    input  logic       phase_done,
    output logic [3:0] cstate,
    output logic       mux_enc_dec,
    output logic       phase_start,
    output logic [1:0] poly_idx,
    output logic       op_busy,
    output logic       op_done,
    output logic       op_err
);

    localparam logic [1:0] c_LAST_IDX = 2'(K);

    logic [3:0] cstate_q, cstate_d;
    logic       mode_q, mode_d;
    logic [1:0] pidx_q, pidx_d;
    logic       pstart_q, pstart_d;
    logic       done_q, done_d;

    logic       w_busy;
    logic       w_accept;
    logic       w_last_pass;
    logic       w_timeout;
    logic [3:0] w_next;

    assign w_busy      = (cstate_q != c_PH_IDLE) && (cstate_q != c_PH_ERR);
    // A done arriving in the start cycle belongs to the previous phase's engine
    assign w_accept    = w_busy && !pstart_q && phase_done;
    assign w_last_pass = (pidx_q == c_LAST_IDX);
    assign w_next      = next_phase(cstate_q, mode_q, w_last_pass);

    always_comb begin
        cstate_d = cstate_q;
        mode_d   = mode_q;
        pidx_d   = pidx_q;
        pstart_d = 1'b0;
        done_d   = 1'b0;
        if (cstate_q == c_PH_IDLE) begin
            pidx_d = 2'd0;
            if (op_start) begin
                cstate_d = c_PH_UNPACK;
                mode_d   = op_mode;
                pstart_d = 1'b1;
            end
        end else if (cstate_q == c_PH_ERR) begin
            if (err_clr) begin
                cstate_d = c_PH_IDLE;
            end
        end else if (op_abort || (cstate_q > c_PH_PACK)) begin
            cstate_d = c_PH_IDLE;
            pidx_d   = 2'd0;
        end else if (w_accept) begin
            cstate_d = w_next;
            if (w_next == c_PH_IDLE) begin
                done_d = 1'b1;
            end else begin
                pstart_d = 1'b1;
            end
            if ((cstate_q == c_PH_INTT) && (mode_q == c_MODE_ENC)) begin
                pidx_d = w_last_pass ? 2'd0 : pidx_q + 2'd1;
            end
        end else if (w_timeout) begin
            cstate_d = c_PH_ERR;
            pidx_d   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cstate_q <= c_PH_IDLE;
            mode_q   <= 1'b0;
            pidx_q   <= 2'd0;
            pstart_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cstate_q <= cstate_d;
            mode_q   <= mode_d;
            pidx_q   <= pidx_d;
            pstart_q <= pstart_d;
            done_q   <= done_d;
        end
    end

    phase_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (cstate_d != cstate_q),
        .busy_i    (w_busy),
        .timeout_o (w_timeout)
    );

    assign cstate      = cstate_q;
    assign mux_enc_dec = mode_q;
    assign phase_start = pstart_q;
    assign poly_idx    = pidx_q;
    assign op_busy     = w_busy;
    assign op_done     = done_q;
    assign op_err      = (cstate_q == c_PH_ERR);

endmodule
`default_nettype wire

// File: tb/tb_kyber_phase_sequencer.sv
`default_nettype none
// ============================================================================
// tb_kyber_phase_sequencer : self-checking bench for kyber_phase_sequencer
// Rev 1.0 - initial release
// ============================================================================
module tb_kyber_phase_sequencer;

    localparam int c_K       = 2;
    localparam int c_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_start = 1'b0;
    logic       op_mode = 1'b0;
    logic       op_abort = 1'b0;
    logic       err_clr = 1'b0;
    logic       phase_done = 1'b0;
    logic [3:0] cstate;
    logic       mux_enc_dec;
    logic       phase_start;
    logic [1:0] poly_idx;
    logic       op_busy;
    logic       op_done;
    logic       op_err;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_code[$];
    int exp_idx[$];

    kyber_phase_sequencer #(
        .K       (c_K),
        .TO_W    (16),
        .TIMEOUT (16'(c_TIMEOUT))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_start    (op_start),
        .op_mode     (op_mode),
        .op_abort    (op_abort),
        .err_clr     (err_clr),
        .phase_done  (phase_done),
        .cstate      (cstate),
        .mux_enc_dec (mux_enc_dec),
        .phase_start (phase_start),
        .poly_idx    (poly_idx),
        .op_busy     (op_busy),
        .op_done     (op_done),
        .op_err      (op_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected phase list and poly index per phase, straight from the phase orders
    function automatic void build_seq(input bit mode);
        exp_code.delete();
        exp_idx.delete();
        exp_code.push_back(1); exp_idx.push_back(0);
        exp_code.push_back(2); exp_idx.push_back(0);
        if (mode) begin
            for (int p = 3; p <= 7; p++) begin
                exp_code.push_back(p); exp_idx.push_back(0);
            end
        end else begin
            exp_code.push_back(9); exp_idx.push_back(0);
            for (int p = 0; p <= c_K; p++) begin
                exp_code.push_back(3); exp_idx.push_back(p);
                exp_code.push_back(4); exp_idx.push_back(p);
            end
            exp_code.push_back(8);  exp_idx.push_back(0);
            exp_code.push_back(10); exp_idx.push_back(0);
            exp_code.push_back(6);  exp_idx.push_back(0);
            exp_code.push_back(11); exp_idx.push_back(0);
        end
    endfunction

    task automatic advance_to(input logic [3:0] tgt, input logic [1:0] idx);
        int n;
        n = 0;
        phase_done = 1'b1;
        while (!(cstate == tgt && poly_idx == idx && phase_start) && n < 100) begin
            step();
            n++;
        end
        phase_done = 1'b0;
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL advance_to: never reached phase %0d idx %0d (at %0d idx %0d)", tgt, idx, cstate, poly_idx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_start = 1'b1; op_mode = 1'b1; phase_done = 1'b1;
        step(); step();
        n_checks++;
        if ({cstate, mux_enc_dec, phase_start, poly_idx, op_busy, op_done, op_err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {cstate, mux_enc_dec, phase_start, poly_idx, op_busy, op_done, op_err});
        end
        op_start = 1'b0; op_mode = 1'b0; phase_done = 1'b0; rst_n = 1'b1;
        step();
        n_checks++;
        if ({cstate, op_busy, op_done} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: cstate %0d busy %b done %b required idle", cstate, op_busy, op_done);
        end
    endtask

    // Full operation from IDLE; ends in the op_done cycle so calls chain back-to-back
    task automatic test_full_op(input bit mode);
        int d;
        build_seq(mode);
        op_mode = mode; op_start = 1'b1;
        step();
        op_mode = 1'($urandom); op_start = 1'b0;
        foreach (exp_code[j]) begin
            d = $urandom_range(1, c_TIMEOUT - 1);
            n_checks++;
            if ({cstate, phase_start, poly_idx, op_busy, op_done, op_err, mux_enc_dec}
                !== {4'(exp_code[j]), 1'b1, 2'(exp_idx[j]), 1'b1, 1'b0, 1'b0, mode}) begin
                n_fail++;
                $display("FAIL phase_entry[%0d]: cstate %0d ps %b idx %0d mux %b required cstate %0d ps 1 idx %0d mux %b",
                         j, cstate, phase_start, poly_idx, mux_enc_dec, exp_code[j], exp_idx[j], mode);
            end
            phase_done = 1'($urandom);
            for (int c = 1; c <= d; c++) begin
                step();
                n_checks++;
                if ({cstate, phase_start, op_done} !== {4'(exp_code[j]), 2'b00}) begin
                    n_fail++;
                    $display("FAIL phase_hold[%0d]: cstate %0d ps %b done %b required cstate %0d ps 0 done 0",
                             j, cstate, phase_start, op_done, exp_code[j]);
                end
                phase_done = (c == d);
                op_start   = (c < d) ? 1'($urandom) : 1'b0;
                op_mode    = 1'($urandom);
            end
            step();
            phase_done = 1'b0;
            op_start   = 1'b0;
        end
        n_checks++;
        if ({cstate, phase_start, poly_idx, op_busy, op_done, op_err} !== {4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL op_complete: cstate %0d ps %b idx %0d busy %b done %b required cstate 0 done 1",
                     cstate, phase_start, poly_idx, op_busy, op_done);
        end
    endtask

    task automatic test_random_ops();
        repeat (6) begin
            test_full_op(1'($urandom));
            repeat ($urandom_range(1, 3)) step();
        end
    endtask

    task automatic test_back_to_back();
        test_full_op(1'b0);
        test_full_op(1'b1);
        step();
        n_checks++;
        if ({cstate, op_done} !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_idle: cstate %0d done %b required 0 0", cstate, op_done);
        end
    endtask

    task automatic test_timeout();
        op_mode = 1'($urandom); op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        phase_done = 1'b1;
        step();
        phase_done = 1'b0;
        n_checks++;
        if ({cstate, phase_start} !== {4'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL to_ntt_entry: cstate %0d ps %b required 2 1", cstate, phase_start);
        end
        for (int c = 1; c < c_TIMEOUT; c++) begin
            step();
            n_checks++;
            if ({cstate, op_err} !== {4'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL to_early[%0d]: cstate %0d err %b required 2 0", c, cstate, op_err);
            end
        end
        step();
        n_checks++;
        if ({cstate, op_err, op_busy, op_done, phase_start} !== {4'd15, 4'b1000}) begin
            n_fail++;
            $display("FAIL to_err: cstate %0d err %b busy %b done %b required 15 1 0 0", cstate, op_err, op_busy, op_done);
        end
        op_start = 1'b1;
        repeat (3) step();
        op_start = 1'b0;
        n_checks++;
        if ({cstate, op_err} !== {4'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL to_err_hold: cstate %0d err %b required 15 1", cstate, op_err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if ({cstate, op_err, op_busy} !== 6'd0) begin
            n_fail++;
            $display("FAIL to_clear: cstate %0d err %b required 0 0", cstate, op_err);
        end
    endtask

    task automatic test_abort();
        op_mode = 1'b1; op_start = 1'b1;
        step();
        op_start = 1'b0;
        advance_to(4'd5, 2'd0);
        step();
        phase_done = 1'b1; op_abort = 1'b1;
        step();
        phase_done = 1'b0; op_abort = 1'b0;
        n_checks++;
        if ({cstate, op_done, op_busy, phase_start, poly_idx} !== 9'd0) begin
            n_fail++;
            $display("FAIL abort_sub: cstate %0d done %b busy %b ps %b required idle no done", cstate, op_done, op_busy, phase_start);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if ({cstate, op_done} !== 5'd0) begin
                n_fail++;
                $display("FAIL abort_stay_idle[%0d]: cstate %0d done %b required 0 0", c, cstate, op_done);
            end
        end
        // abort on the cycle the watchdog would fire, mid-loop with poly_idx 1
        op_mode = 1'b0; op_start = 1'b1;
        step();
        op_start = 1'b0;
        advance_to(4'd3, 2'd1);
        for (int c = 1; c < c_TIMEOUT; c++) step();
        op_abort = 1'b1;
        step();
        op_abort = 1'b0;
        n_checks++;
        if ({cstate, op_err, op_done, poly_idx} !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_vs_timeout: cstate %0d err %b done %b idx %0d required 0 0 0 0", cstate, op_err, op_done, poly_idx);
        end
    endtask

    task automatic test_edge_cases();
        op_mode = 1'b0; op_start = 1'b1;
        step();
        op_start = 1'b0;
        advance_to(4'd3, 2'd0);
        op_start = 1'b1; op_mode = 1'b1;
        step(); step();
        op_start = 1'b0;
        n_checks++;
        if ({cstate, mux_enc_dec, phase_start} !== {4'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL start_in_pacc: cstate %0d mux %b ps %b required 3 0 0", cstate, mux_enc_dec, phase_start);
        end
        advance_to(4'd4, 2'd0);
        phase_done = 1'b1;
        step();
        phase_done = 1'b0;
        n_checks++;
        if ({cstate, phase_start} !== {4'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL done_in_start_cycle: cstate %0d ps %b required 4 0", cstate, phase_start);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({cstate, mux_enc_dec, phase_start, poly_idx, op_busy, op_done, op_err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_intt: got %h required 0", {cstate, mux_enc_dec, phase_start, poly_idx, op_busy, op_done, op_err});
        end
        rst_n = 1'b1;
        test_full_op(1'b1);
        step();
    endtask

    initial begin
        test_reset();
        test_full_op(1'b1);
        step();
        test_full_op(1'b0);
        step();
        test_random_ops();
        test_back_to_back();
        test_timeout();
        test_abort();
        test_edge_cases();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
